// File: rtl/acc_csr_pkg.sv
// acc_csr_pkg: shared definitions for the accelerator CSR front end.
//   - register word addresses on the 3-bit Avalon-MM address bus
//   - CTRL / STATUS bit positions
//   - control FSM state encoding
//   - saturating 64-bit increment used by the cycle timer
package acc_csr_pkg;

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_CYC_LO  = 3'd2;
  localparam logic [2:0] ADDR_CYC_HI  = 3'd3;
  localparam logic [2:0] ADDR_TIMEOUT = 3'd4;
  localparam logic [2:0] ADDR_RUNS    = 3'd5;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_TIMEOUT  = 2;
  localparam int STAT_OVERRUN  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [63:0] sat_inc64(input logic [63:0] v);
    return (&v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/acc_cycle_timer.sv
// acc_cycle_timer: 64-bit saturating run-length counter plus watchdog compare.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : zero the counter (takes priority over en)
//   en           : count this cycle
//   limit        : watchdog limit, 0 disables (only with ACC_CSR_TIMEOUT_EN)
//   expire       : strobe in the counting cycle where count+1 == limit
//                  (only with ACC_CSR_TIMEOUT_EN)
//   count_inc    : saturated count+1, i.e. the elapsed length if the run
//                  ended in this cycle
// Build option: ACC_CSR_TIMEOUT_EN compiles in the watchdog compare.
module acc_cycle_timer
  import acc_csr_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        en,
`ifdef ACC_CSR_TIMEOUT_EN
  input  logic [31:0] limit,
  output logic        expire,
`endif
  output logic [63:0] count_inc
);

  logic [63:0] count_q, count_d;

  assign count_inc = sat_inc64(count_q);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

`ifdef ACC_CSR_TIMEOUT_EN
  assign expire = en && (limit != 32'd0) && (count_inc == {32'd0, limit});
`endif

endmodule

// File: rtl/acc_csr_ctrl.sv
// acc_csr_ctrl: HPS lightweight-bus CSR block that launches the cycle
// accelerator, times each run, watches for a hung run and raises an IRQ.
//   clk, reset_n        : clock, asynchronous active-low reset
//   avs_address/write/writedata/read/readdata : Avalon-MM slave, read latency 1
//   o_start             : one-cycle start pulse to the accelerator
//   i_finish            : one-cycle completion pulse from the accelerator
//   o_irq               : registered level interrupt IRQ_EN & (DONE | TIMEOUT)
// Build option: ACC_CSR_TIMEOUT_EN adds the TIMEOUT register and watchdog;
// without it TIMEOUT reads 0 and a run ends only on i_finish.
module acc_csr_ctrl
  import acc_csr_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_RST = 32'd0
)(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        o_start,
  input  logic        i_finish,
  output logic        o_irq
);

  state_e      state_q, state_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        tout_q, tout_d;
  logic        ovr_q, ovr_d;
  logic        irq_q, irq_d;
  logic [63:0] cycles_q, cycles_d;
  logic [31:0] runs_q, runs_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] timeout_lim;
  logic [31:0] rd_mux;

  logic        ctrl_wr, start_req, clear_req;
  logic        timer_clr, timer_en, expire;
  logic [63:0] count_inc;

  assign ctrl_wr   = avs_write && (avs_address == ADDR_CTRL);
  assign start_req = ctrl_wr && avs_writedata[CTRL_START];
  // A write carrying both START and CLEAR is treated purely as a START.
  assign clear_req = ctrl_wr && avs_writedata[CTRL_CLEAR] && !avs_writedata[CTRL_START];
  assign timer_clr = (state_q == ST_IDLE) && start_req;
  assign timer_en  = (state_q == ST_RUN);

`ifdef ACC_CSR_TIMEOUT_EN
  logic [31:0] timeout_q, timeout_d;

  always_comb begin
    timeout_d = timeout_q;
    if (avs_write && (avs_address == ADDR_TIMEOUT)) begin
      timeout_d = avs_writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_q <= TIMEOUT_RST;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout_lim = timeout_q;

  acc_cycle_timer u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (timer_clr),
    .en        (timer_en),
    .limit     (timeout_lim),
    .expire    (expire),
    .count_inc (count_inc)
  );
`else
  // No watchdog: the register reads as zero and never fires.
  assign timeout_lim = '0;
  assign expire      = 1'b0;

  // Upper write-data bits and the reset limit have no function here.
  logic unused_inputs;
  assign unused_inputs = ^{avs_writedata[31:3], TIMEOUT_RST};

  acc_cycle_timer u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (timer_clr),
    .en        (timer_en),
    .count_inc (count_inc)
  );
`endif

  // Control FSM and flag updates. Clears are applied first so that any set
  // in the same cycle overrides them.
  always_comb begin
    state_d  = state_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    tout_d   = tout_q;
    ovr_d    = ovr_q;
    cycles_d = cycles_q;
    runs_d   = runs_q;

    if (ctrl_wr) begin
      irq_en_d = avs_writedata[CTRL_IRQ_EN];
    end
    if (clear_req) begin
      done_d = 1'b0;
      tout_d = 1'b0;
      ovr_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d = ST_LAUNCH;
          done_d  = 1'b0;
          tout_d  = 1'b0;
          ovr_d   = 1'b0;
        end
      end
      ST_LAUNCH: begin
        if (start_req) begin
          ovr_d = 1'b1;
        end
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start_req) begin
          ovr_d = 1'b1;
        end
        // Finish takes precedence over a coincident watchdog expiry.
        if (i_finish) begin
          cycles_d = count_inc;
          done_d   = 1'b1;
          runs_d   = runs_q + 32'd1;
          state_d  = ST_IDLE;
        end else if (expire) begin
          tout_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    irq_d = irq_en_q && (done_q || tout_q);
  end

  // Read mux reflects register state of the cycle the read is issued in.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_CTRL:    rd_mux[CTRL_IRQ_EN] = irq_en_q;
      ADDR_STATUS: begin
        rd_mux[STAT_BUSY]    = (state_q != ST_IDLE);
        rd_mux[STAT_DONE]    = done_q;
        rd_mux[STAT_TIMEOUT] = tout_q;
        rd_mux[STAT_OVERRUN] = ovr_q;
      end
      ADDR_CYC_LO:  rd_mux = cycles_q[31:0];
      ADDR_CYC_HI:  rd_mux = cycles_q[63:32];
      ADDR_TIMEOUT: rd_mux = timeout_lim;
      ADDR_RUNS:    rd_mux = runs_q;
      default:      rd_mux = '0;
    endcase
    rdata_d = avs_read ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      tout_q   <= 1'b0;
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
      cycles_q <= '0;
      runs_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      tout_q   <= tout_d;
      ovr_q    <= ovr_d;
      irq_q    <= irq_d;
      cycles_q <= cycles_d;
      runs_q   <= runs_d;
      rdata_q  <= rdata_d;
    end
  end

  assign o_start      = (state_q == ST_LAUNCH);
  assign o_irq        = irq_q;
  assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_acc_csr_ctrl.sv
// tb_acc_csr_ctrl: self-checking bench for acc_csr_ctrl. A run-level model
// predicts each run's outcome (finish vs. watchdog, elapsed length, flags)
// from the finish delay and the programmed limit; registers are read back
// and compared after every run. Honours ACC_CSR_TIMEOUT_EN.
module tb_acc_csr_ctrl;
  import acc_csr_pkg::*;

  localparam logic [31:0] TRST = 32'd1000;
`ifdef ACC_CSR_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        o_start;
  logic        i_finish;
  logic        o_irq;

  acc_csr_ctrl #(.TIMEOUT_RST(TRST)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .o_start       (o_start),
    .i_finish      (i_finish),
    .o_irq         (o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  always @(posedge clk) if (o_start === 1'b1) start_cnt++;

  // Run-level reference model.
  bit          m_irq_en, m_done, m_tout, m_ovr;
  logic [63:0] m_cycles;
  logic [31:0] m_runs, m_timeout;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_irq_en = 0; m_done = 0; m_tout = 0; m_ovr = 0;
    m_cycles = '0; m_runs = '0;
    m_timeout = WD ? TRST : 32'd0;
  endtask

  function automatic logic [31:0] model_reg(input logic [2:0] a);
    case (a)
      ADDR_CTRL:    return {29'd0, m_irq_en, 2'b00};
      ADDR_STATUS:  return {28'd0, m_ovr, m_tout, m_done, 1'b0};
      ADDR_CYC_LO:  return m_cycles[31:0];
      ADDR_CYC_HI:  return m_cycles[63:32];
      ADDR_TIMEOUT: return m_timeout;
      ADDR_RUNS:    return m_runs;
      default:      return 32'd0;
    endcase
  endfunction

  // Bus tasks are entered and left on a falling edge.
  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    d = avs_readdata;
    avs_read = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] d;
    for (int a = 0; a < 8; a++) begin
      do_read(3'(a), d);
      check_val($sformatf("%s_reg%0d", tag, a), d, model_reg(3'(a)));
    end
  endtask

  // One run: START (cycle -1), o_start in cycle 0, i_finish driven in cycle k.
  // Optionally a second START in cycle 2 while busy.
  task automatic do_run(input int k, input bit ien, input bit ovr_inj);
    int  t, e, last, s0;
    bit  wd_hit, ovr_do;
    t      = int'(m_timeout);
    wd_hit = WD && (t != 0) && (t < k);
    e      = wd_hit ? t : k;
    ovr_do = ovr_inj && (e > 2);

    m_irq_en = ien; m_done = 0; m_tout = 0; m_ovr = 0;
    s0 = start_cnt;
    do_write(ADDR_CTRL, {29'd0, ien, 2'b01});
    check_val("start_pulse", o_start, 1);

    if (ovr_do) m_ovr = 1;
    if (wd_hit) m_tout = 1;
    else begin
      m_done = 1; m_cycles = 64'(k); m_runs = m_runs + 32'd1;
    end

    last = (k > e + 2) ? k : e + 2;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      i_finish = 1'b0; avs_write = 1'b0; avs_read = 1'b0;
      if (c == k) i_finish = 1'b1;
      if (ovr_do && c == 2) begin
        avs_address = ADDR_CTRL; avs_writedata = {29'd0, ien, 2'b01}; avs_write = 1'b1;
      end
      if (c == e + 1) begin
        check_val("irq_pre", o_irq, 0);
        avs_address = ADDR_STATUS; avs_read = 1'b1;
      end
      if (c == e + 2) begin
        check_val("irq_post", o_irq, 64'(ien));
        check_val("status_end", avs_readdata, model_reg(ADDR_STATUS));
      end
    end
    @(negedge clk);
    i_finish = 1'b0; avs_write = 1'b0; avs_read = 1'b0;
    check_val("start_once", 64'(start_cnt - s0), 1);
    $display("run k=%0d limit=%0d irq_en=%0d ovr=%0d -> %s", k, t, ien, ovr_do,
             wd_hit ? "timeout" : "done");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_watchdog: time limit reached with %0d checks", checks);
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] d, tv;
    int k;
    bit ien, ovr;

    reset_n = 1'b0; avs_address = '0; avs_write = 1'b0; avs_writedata = '0;
    avs_read = 1'b0; i_finish = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_start", o_start, 0);
    check_val("rst_irq", o_irq, 0);
    check_val("rst_rdata", avs_readdata, 0);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_regs("rst");

    // Basic run with IRQ, then clear it.
    do_run(50, 1'b1, 1'b0);
    check_regs("run50");
    do_write(ADDR_CTRL, 32'h6);
    m_irq_en = 1; m_done = 0; m_tout = 0; m_ovr = 0;
    check_val("irq_hold", o_irq, 1);
    @(negedge clk);
    check_val("irq_clr", o_irq, 0);
    check_regs("clr");

    // Watchdog expiry with a late finish, then finish on the expiry cycle.
    do_write(ADDR_TIMEOUT, 32'd20);
    if (WD) m_timeout = 32'd20;
    do_run(30, 1'b1, 1'b0);
    check_regs("wd");
    do_run(20, 1'b0, 1'b0);
    check_regs("wd_edge");

    // START while busy.
    do_run(40, 1'b1, 1'b1);
    check_regs("ovr");

    // Randomised runs.
    for (int i = 0; i < 10; i++) begin
      tv = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 60));
      do_write(ADDR_TIMEOUT, tv);
      if (WD) m_timeout = tv;
      if ($urandom_range(0, 1) == 1) begin
        do_write(3'($urandom_range(6, 7)), $urandom);
      end
      k   = int'($urandom_range(1, 60));
      ien = 1'($urandom_range(0, 1));
      ovr = 1'($urandom_range(0, 1));
      do_run(k, ien, ovr);
      check_regs($sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) begin
        do_write(ADDR_CTRL, {29'd0, ien, 2'b10});
        m_done = 0; m_tout = 0; m_ovr = 0;
        check_regs($sformatf("rndclr%0d", i));
      end
    end

    // Reset in the middle of a run.
    do_write(ADDR_TIMEOUT, 32'd0);
    if (WD) m_timeout = 32'd0;
    do_write(ADDR_CTRL, 32'h5);
    repeat (7) @(negedge clk);
    do_read(ADDR_RUNS, d);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("arst_start", o_start, 0);
    check_val("arst_irq", o_irq, 0);
    check_val("arst_rdata", avs_readdata, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_regs("post_rst");
    do_run(15, 1'b1, 1'b0);
    check_regs("after_rst_run");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
